// File: rtl/writeback_scheduler_if.sv
// Bundle for the writeback scheduler: pipeline and long-latency result streams in, register-bank write port out.
// Define WB_BYPASS_EN to add the read-bypass signals (source regs, bank read data, forwarded data).
interface writeback_scheduler_if #(
    parameter int WORD_LEN     = 32,
    parameter int REG_ADDR_LEN = 5,
    parameter int FIFO_DEPTH   = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic                    pipeValid;
    logic [REG_ADDR_LEN-1:0] pipeDest;
    logic [WORD_LEN-1:0]     pipeData;
    logic                    llValid;
    logic                    llReady;
    logic [REG_ADDR_LEN-1:0] llDest;
    logic [WORD_LEN-1:0]     llData;
    logic                    writeEnable;
    logic [REG_ADDR_LEN-1:0] destinationReg;
    logic [WORD_LEN-1:0]     dataIn;
    logic [CNT_W-1:0]        llCount;
    logic                    llPending;
`ifdef WB_BYPASS_EN
    logic [REG_ADDR_LEN-1:0] sourceReg1;
    logic [REG_ADDR_LEN-1:0] sourceReg2;
    logic [WORD_LEN-1:0]     bankData1;
    logic [WORD_LEN-1:0]     bankData2;
    logic [WORD_LEN-1:0]     data1Out;
    logic [WORD_LEN-1:0]     data2Out;

    modport master (
        output pipeValid, pipeDest, pipeData, llValid, llDest, llData,
               sourceReg1, sourceReg2, bankData1, bankData2,
        input  llReady, writeEnable, destinationReg, dataIn, llCount, llPending,
               data1Out, data2Out
    );
    modport slave (
        input  pipeValid, pipeDest, pipeData, llValid, llDest, llData,
               sourceReg1, sourceReg2, bankData1, bankData2,
        output llReady, writeEnable, destinationReg, dataIn, llCount, llPending,
               data1Out, data2Out
    );
`else
    modport master (
        output pipeValid, pipeDest, pipeData, llValid, llDest, llData,
        input  llReady, writeEnable, destinationReg, dataIn, llCount, llPending
    );
    modport slave (
        input  pipeValid, pipeDest, pipeData, llValid, llDest, llData,
        output llReady, writeEnable, destinationReg, dataIn, llCount, llPending
    );
`endif
endinterface

// File: rtl/writeback_scheduler.sv
// Merges pipeline results and FIFO-buffered long-latency results onto the single register-bank write port.
// Optional WB_BYPASS_EN forwards the write currently on the port to the two read ports.
module writeback_scheduler #(
    parameter int WORD_LEN     = 32,
    parameter int REG_ADDR_LEN = 5,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    writeback_scheduler_if.slave  io_wb
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [REG_ADDR_LEN-1:0] r_fifoDest [FIFO_DEPTH];
    logic [WORD_LEN-1:0]     r_fifoData [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_head;
    logic [PTR_W-1:0]        r_tail;
    logic [CNT_W-1:0]        r_count;
    logic                    r_writeEnable;
    logic [REG_ADDR_LEN-1:0] r_destReg;
    logic [WORD_LEN-1:0]     r_dataIn;

    logic w_llReady;
    logic w_llAccept;
    logic w_pipeIssue;
    logic w_fifoEmpty;
    logic w_pop;
    logic w_cutThrough;
    logic w_push;

    // Ready uses only the registered count, so a full FIFO never takes a new entry in the cycle it pops.
    assign w_llReady    = (r_count < CNT_W'(FIFO_DEPTH));
    assign w_llAccept   = io_wb.llValid && w_llReady;
    assign w_pipeIssue  = io_wb.pipeValid && (io_wb.pipeDest != '0);
    assign w_fifoEmpty  = (r_count == '0);
    assign w_pop        = !w_pipeIssue && !w_fifoEmpty;
    assign w_cutThrough = !w_pipeIssue && w_fifoEmpty && w_llAccept && (io_wb.llDest != '0);
    assign w_push       = w_llAccept && (io_wb.llDest != '0) && !w_cutThrough;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_writeEnable <= 1'b0;
            r_destReg     <= '0;
            r_dataIn      <= '0;
        end else begin
            if (w_pipeIssue) begin
                r_writeEnable <= 1'b1;
                r_destReg     <= io_wb.pipeDest;
                r_dataIn      <= io_wb.pipeData;
            end else if (w_pop) begin
                r_writeEnable <= 1'b1;
                r_destReg     <= r_fifoDest[r_head];
                r_dataIn      <= r_fifoData[r_head];
            end else if (w_cutThrough) begin
                r_writeEnable <= 1'b1;
                r_destReg     <= io_wb.llDest;
                r_dataIn      <= io_wb.llData;
            end else begin
                r_writeEnable <= 1'b0;
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Storage needs no reset: only slots between head and tail are ever read.
    always_ff @(posedge i_clk) begin
        if (!i_reset && w_push) begin
            r_fifoDest[r_tail] <= io_wb.llDest;
            r_fifoData[r_tail] <= io_wb.llData;
        end
    end

    assign io_wb.llReady        = w_llReady;
    assign io_wb.writeEnable    = r_writeEnable;
    assign io_wb.destinationReg = r_destReg;
    assign io_wb.dataIn         = r_dataIn;
    assign io_wb.llCount        = r_count;
    assign io_wb.llPending      = !w_fifoEmpty;

`ifdef WB_BYPASS_EN
    assign io_wb.data1Out = (r_writeEnable && (r_destReg == io_wb.sourceReg1) && (io_wb.sourceReg1 != '0))
                            ? r_dataIn : io_wb.bankData1;
    assign io_wb.data2Out = (r_writeEnable && (r_destReg == io_wb.sourceReg2) && (io_wb.sourceReg2 != '0))
                            ? r_dataIn : io_wb.bankData2;
`endif
endmodule

// File: tb/tb_writeback_scheduler.sv
// Self-checking bench for writeback_scheduler: directed scenarios plus randomized traffic against a queue-based model.
// Build with WB_BYPASS_EN defined to also check the read bypass.
module tb_writeback_scheduler;
    localparam int WORD_LEN     = 32;
    localparam int REG_ADDR_LEN = 5;
    localparam int FIFO_DEPTH   = 4;

    typedef struct {
        logic [REG_ADDR_LEN-1:0] dest;
        logic [WORD_LEN-1:0]     data;
    } llEntry_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    writeback_scheduler_if #(.WORD_LEN(WORD_LEN), .REG_ADDR_LEN(REG_ADDR_LEN), .FIFO_DEPTH(FIFO_DEPTH)) bus();

    writeback_scheduler #(.WORD_LEN(WORD_LEN), .REG_ADDR_LEN(REG_ADDR_LEN), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .io_wb   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    llEntry_t                modelQ[$];
    logic                    modelWe;
    logic [REG_ADDR_LEN-1:0] modelDest;
    logic [WORD_LEN-1:0]     modelData;
    bit                      modelValid = 1'b0;
    bit                      lastAccept;

    logic [REG_ADDR_LEN-1:0] bpSrc1 = '0;
    logic [REG_ADDR_LEN-1:0] bpSrc2 = '0;
    logic [WORD_LEN-1:0]     bpBank1 = '0;
    logic [WORD_LEN-1:0]     bpBank2 = '0;
    bit                      bpRandom = 1'b1;

    task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(string phase);
        if (modelValid) begin
            checkOutput({phase, ".we"},      32'(bus.writeEnable),    32'(modelWe));
            checkOutput({phase, ".dest"},    32'(bus.destinationReg), 32'(modelDest));
            checkOutput({phase, ".data"},    32'(bus.dataIn),         32'(modelData));
            checkOutput({phase, ".count"},   32'(bus.llCount),        32'(modelQ.size()));
            checkOutput({phase, ".pending"}, 32'(bus.llPending),      32'(modelQ.size() != 0));
            checkOutput({phase, ".ready"},   32'(bus.llReady),        32'(modelQ.size() < FIFO_DEPTH));
        end
    endtask

    task automatic applyStimulus(bit rst, bit pv, logic [REG_ADDR_LEN-1:0] pd, logic [WORD_LEN-1:0] pdat,
                                 bit lv, logic [REG_ADDR_LEN-1:0] ld, logic [WORD_LEN-1:0] ldat);
        reset         = rst;
        bus.pipeValid = pv;
        bus.pipeDest  = pd;
        bus.pipeData  = pdat;
        bus.llValid   = lv;
        bus.llDest    = ld;
        bus.llData    = ldat;
    endtask

    // Reference: pipeline beats everything, then the oldest queued LL write, then a direct LL write.
    task automatic modelStep(bit rst, bit pv, logic [REG_ADDR_LEN-1:0] pd, logic [WORD_LEN-1:0] pdat,
                             bit lv, logic [REG_ADDR_LEN-1:0] ld, logic [WORD_LEN-1:0] ldat);
        bit accept;
        bit direct;
        llEntry_t e;
        accept = lv && (modelQ.size() < FIFO_DEPTH);
        direct = 1'b0;
        lastAccept = 1'b0;
        if (rst) begin
            modelWe = 1'b0;
            modelDest = '0;
            modelData = '0;
            modelQ.delete();
            modelValid = 1'b1;
            return;
        end
        lastAccept = accept;
        if (pv && pd != 0) begin
            modelWe = 1'b1; modelDest = pd; modelData = pdat;
        end else if (modelQ.size() > 0) begin
            e = modelQ.pop_front();
            modelWe = 1'b1; modelDest = e.dest; modelData = e.data;
        end else if (accept && ld != 0) begin
            modelWe = 1'b1; modelDest = ld; modelData = ldat;
            direct = 1'b1;
        end else begin
            modelWe = 1'b0;
        end
        if (accept && ld != 0 && !direct) begin
            e.dest = ld;
            e.data = ldat;
            modelQ.push_back(e);
        end
    endtask

    task automatic runCycle(string phase, bit rst, bit pv, logic [REG_ADDR_LEN-1:0] pd, logic [WORD_LEN-1:0] pdat,
                            bit lv, logic [REG_ADDR_LEN-1:0] ld, logic [WORD_LEN-1:0] ldat);
        @(negedge clk);
        checkAll(phase);
        applyStimulus(rst, pv, pd, pdat, lv, ld, ldat);
`ifdef WB_BYPASS_EN
        if (bpRandom) begin
            bpSrc1  = ($urandom % 2 == 0) ? modelDest : REG_ADDR_LEN'($urandom);
            bpSrc2  = ($urandom % 2 == 0) ? modelDest : REG_ADDR_LEN'($urandom);
            bpBank1 = $urandom;
            bpBank2 = $urandom;
        end
        bus.sourceReg1 = bpSrc1;
        bus.sourceReg2 = bpSrc2;
        bus.bankData1  = bpBank1;
        bus.bankData2  = bpBank2;
`endif
        #1;
`ifdef WB_BYPASS_EN
        if (modelValid && !rst) begin
            checkOutput({phase, ".bypass1"}, bus.data1Out,
                        (modelWe && modelDest == bpSrc1 && bpSrc1 != 0) ? modelData : bpBank1);
            checkOutput({phase, ".bypass2"}, bus.data2Out,
                        (modelWe && modelDest == bpSrc2 && bpSrc2 != 0) ? modelData : bpBank2);
        end
`endif
        modelStep(rst, pv, pd, pdat, lv, ld, ldat);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int nextDest;
        logic [REG_ADDR_LEN-1:0] drainLog[$];
        bit holdLv;
        logic [REG_ADDR_LEN-1:0] holdLd;
        logic [WORD_LEN-1:0] holdLdat;
        bit rpv;
        logic [REG_ADDR_LEN-1:0] rpd;

        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        $display("[TB] start");

        // Reset held two cycles while LL offers a write: nothing must be captured.
        runCycle("reset", 1'b1, 1'b0, '0, '0, 1'b1, 5'd3, 32'h33);
        runCycle("reset", 1'b1, 1'b0, '0, '0, 1'b1, 5'd3, 32'h33);
        runCycle("reset", 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        checkOutput("reset.we",    32'(bus.writeEnable), 32'd0);
        checkOutput("reset.count", 32'(bus.llCount),     32'd0);
        checkOutput("reset.ready", 32'(bus.llReady),     32'd1);

        // Pipeline-only writes, then an R0 write that must be suppressed.
        runCycle("pipe", 1'b0, 1'b1, 5'd5, 32'h55, 1'b0, '0, '0);
        runCycle("pipe", 1'b0, 1'b1, 5'd0, 32'h77, 1'b0, '0, '0);
        checkOutput("pipe.we",   32'(bus.writeEnable),    32'd1);
        checkOutput("pipe.dest", 32'(bus.destinationReg), 32'd5);
        checkOutput("pipe.data", bus.dataIn,              32'h55);
        runCycle("pipe", 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        checkOutput("pipe.r0we",   32'(bus.writeEnable),    32'd0);
        checkOutput("pipe.r0hold", 32'(bus.destinationReg), 32'd5);

        // Cut-through with an empty FIFO.
        runCycle("cut", 1'b0, 1'b0, '0, '0, 1'b1, 5'd9, 32'h99);
        runCycle("cut", 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        checkOutput("cut.we",    32'(bus.writeEnable),    32'd1);
        checkOutput("cut.dest",  32'(bus.destinationReg), 32'd9);
        checkOutput("cut.data",  bus.dataIn,              32'h99);
        checkOutput("cut.count", 32'(bus.llCount),        32'd0);

        // Contention: pipeline busy for six cycles while LL offers dests 1..5.
        nextDest = 1;
        for (int c = 0; c < 6; c++) begin
            runCycle("contend", 1'b0, 1'b1, REG_ADDR_LEN'(20 + c), 32'h1000 + c,
                     nextDest <= 5, REG_ADDR_LEN'(nextDest), 32'hA0 + nextDest);
            if (lastAccept) nextDest++;
        end
        checkOutput("contend.count", 32'(bus.llCount), 32'd4);
        checkOutput("contend.ready", 32'(bus.llReady), 32'd0);
        for (int c = 0; c < 8; c++) begin
            runCycle("drain", 1'b0, 1'b0, '0, '0, nextDest <= 5, REG_ADDR_LEN'(nextDest), 32'hA0 + nextDest);
            if (lastAccept) nextDest++;
            if (bus.writeEnable && bus.destinationReg <= 5) drainLog.push_back(bus.destinationReg);
        end
        checkOutput("drain.len", 32'(drainLog.size()), 32'd5);
        for (int i = 0; i < drainLog.size(); i++) begin
            checkOutput($sformatf("drain.order%0d", i), 32'(drainLog[i]), 32'(i + 1));
        end
        checkOutput("drain.count", 32'(bus.llCount), 32'd0);

        // Simultaneous push and pop with two entries queued.
        runCycle("pushpop", 1'b0, 1'b1, 5'd30, 32'h3000, 1'b1, 5'd11, 32'hB11);
        runCycle("pushpop", 1'b0, 1'b1, 5'd31, 32'h3001, 1'b1, 5'd12, 32'hB12);
        for (int c = 0; c < 6; c++) begin
            runCycle("pushpop", 1'b0, 1'b0, '0, '0, 1'b1, REG_ADDR_LEN'(13 + c), 32'hB13 + c);
            checkOutput($sformatf("pushpop.count%0d", c), 32'(bus.llCount), 32'd2);
        end
        for (int c = 0; c < 3; c++) runCycle("pushpop", 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);

`ifdef WB_BYPASS_EN
        bpRandom = 1'b0;
        bpSrc1 = 5'd7; bpSrc2 = 5'd0; bpBank1 = 32'h1111; bpBank2 = 32'h2222;
        runCycle("bypass", 1'b0, 1'b1, 5'd7, 32'hDEAD, 1'b0, '0, '0);
        runCycle("bypass", 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        checkOutput("bypass.fwd1",  bus.data1Out, 32'hDEAD);
        checkOutput("bypass.bank2", bus.data2Out, 32'h2222);
        bpRandom = 1'b1;
`endif

        // Randomized traffic; LL offers stay stable until accepted.
        holdLv = 1'b0; holdLd = '0; holdLdat = '0;
        for (int c = 0; c < 500; c++) begin
            bit rrst;
            rrst = ($urandom % 150 == 0);
            if (!holdLv || lastAccept) begin
                holdLv   = ($urandom % 3 != 0);
                holdLd   = REG_ADDR_LEN'($urandom);
                holdLdat = $urandom;
            end
            rpv = (c % 100 < 50) ? ($urandom % 4 != 0) : ($urandom % 4 == 0);
            rpd = ($urandom % 8 == 0) ? '0 : REG_ADDR_LEN'($urandom);
            runCycle("random", rrst, rpv, rpd, $urandom, holdLv, holdLd, holdLdat);
            if (rrst) holdLv = 1'b0;
        end
        runCycle("final", 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        @(negedge clk);
        checkAll("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
